sync_fifo_burst_reader: RTL and testbench
=========================================

Name: sync_fifo_burst_reader

Overview:
Read-side engine for the team's synchronous FIFO (registered read data, one cycle after an accepted rd_en). It accepts a burst command of N words and pops exactly N words from the FIFO. Words are presented on a valid/ready output stream with a last flag and a completion pulse. Sits between the FIFO and any downstream consumer that applies backpressure.

Parameters:
DATA_WIDTH, 8, width of FIFO data and output stream data
LEN_WIDTH, 8, width of burst length; max burst 2^LEN_WIDTH-1 words

Ports:
clk  input  1  clock
rst  input  1  reset; synchronous, active-high
cmd_valid  input  1  burst command request
cmd_ready  output  1  block can accept a command (high only in IDLE)
cmd_len  input  LEN_WIDTH  number of words to read; sampled on cmd handshake
fifo_empty  input  1  FIFO empty flag
fifo_rd_en  output  1  FIFO read request
fifo_data  input  DATA_WIDTH  FIFO read data; valid the cycle after an accepted read
m_valid  output  1  output word valid
m_ready  input  1  downstream accepts word
m_data  output  DATA_WIDTH  output word
m_last  output  1  marks final word of burst
busy  output  1  state != IDLE
done  output  1  one-cycle pulse after the last word's handshake (or after a zero-length command)

Behaviour:
- Reset: state IDLE, counters 0, skid buffer emptied, inflight 0. fifo_rd_en forced 0 while rst is high. m_valid=0, m_data=0, m_last=0, done=0, busy=0. cmd_ready=1 from the first cycle after rst deasserts.
- States:
  - IDLE: cmd_ready=1. Handshake with cmd_len=0 -> done pulse next cycle, stay IDLE. cmd_len>0 -> req_left=out_left=cmd_len, go READ.
  - READ: issue reads. When the last read is issued (req_left 1->0) -> DRAIN.
  - DRAIN: no reads issued. Handshake of the word with out_left==1 -> IDLE, done=1 that next cycle.
- Read issue: fifo_rd_en = (state==READ) && !fifo_empty && req_left!=0 && (occ + inflight) < 3.
  - occ is registered skid-buffer occupancy (0..3); inflight is a 1-bit register equal to the previous cycle's fifo_rd_en.
  - No combinational path from m_ready to fifo_rd_en.
  - Each issued read decrements req_left.
- Capture: when inflight==1, fifo_data is written to the buffer tail that cycle. Capture and pop in the same cycle are legal; occ is unchanged.
- Skid buffer: 3-entry FIFO with in-order output.
  - m_valid = occ!=0; m_data = head entry.
  - m_last = m_valid && out_left==1.
  - Pop on m_valid && m_ready; each pop decrements out_left.
  - m_data and m_last hold stable while m_valid && !m_ready.
- Latency: cmd handshake in cycle 0 -> fifo_rd_en in cycle 1 (if not empty) -> m_valid in cycle 3.
- Throughput: 1 word/cycle sustained with m_ready=1 and FIFO non-empty.
- Backpressure: with m_ready held low, at most 3 words are in buffer plus in flight. No read is issued that could overflow.
- Underrun: fifo_empty high stalls issue only; the burst resumes when data appears. No timeout.
- cmd_valid while busy is ignored (cmd_ready=0).
- Reset mid-burst: aborts immediately. Buffered and in-flight words are discarded, and no done pulse is produced.
- Counters are LEN_WIDTH bits and never wrap below 0.

Decomposition:
- Package sync_fifo_pkg: state enum (IDLE, READ, DRAIN) and constant SKID_DEPTH=3. Shared with the FIFO's DATA_WIDTH default.
- One sub-module, fifo_rd_skid_buf: 3-entry buffer with push, pop, head data and occ count. The FSM, counters and issue logic stay in the top module.

Test Plan:
- Reset: assert rst 2 cycles mid-traffic -> next cycle m_valid=0, m_last=0, fifo_rd_en=0, busy=0, done=0; cmd_ready=1 after release.
- Basic burst: FIFO preloaded 0x11..0x15, cmd_len=5, m_ready=1 -> fifo_rd_en high 5 consecutive cycles; m_data 11,12,13,14,15 on consecutive cycles starting 3 cycles after cmd; m_last only with 0x15; done one cycle later.
- Backpressure: preload 8 words, cmd_len=8, m_ready=0 for 6 cycles then 1 -> exactly 3 reads issued before the stall; all 8 words delivered in order with no duplicates; m_data stable while stalled.
- Underrun: FIFO empty, cmd_len=3, write 0xA1, 0xA2, 0xA3 at 4-cycle gaps -> fifo_rd_en only when fifo_empty=0; 3 words out, m_last on 0xA3, done pulse.
- Zero length: cmd_len=0 -> done high next cycle; fifo_rd_en and m_valid never asserted; busy stays 0.
- Abort: cmd_len=6, rst after the 2nd output handshake -> outputs cleared next cycle, no done; new cmd_len=2 with fresh FIFO data completes normally.

Source files
------------

// File: rtl/sync_fifo_burst_reader_pkg.sv
// Shared types and constants for the sync FIFO read-side engine.
// Also carries the FIFO's default data width.
package sync_fifo_pkg;

    localparam int DATA_WIDTH_DEF = 8;
    localparam int SKID_DEPTH     = 3;

    typedef enum logic [1:0] {
        IDLE,
        READ,
        DRAIN
    } rd_state_e;

endpackage

// File: rtl/sync_fifo_burst_reader_if.sv
// Command, FIFO-read and output-stream signals of the burst reader.
// slave = the reader, master = the surrounding logic.
interface sync_fifo_burst_reader_if
    import sync_fifo_pkg::*;
#(
    parameter int DATA_WIDTH = DATA_WIDTH_DEF,
    parameter int LEN_WIDTH  = 8
);

    logic                  cmd_valid;
    logic                  cmd_ready;
    logic [LEN_WIDTH-1:0]  cmd_len;
    logic                  fifo_empty;
    logic                  fifo_rd_en;
    logic [DATA_WIDTH-1:0] fifo_data;
    logic                  m_valid;
    logic                  m_ready;
    logic [DATA_WIDTH-1:0] m_data;
    logic                  m_last;
    logic                  busy;
    logic                  done;

    modport master (
        output cmd_valid, cmd_len, fifo_empty, fifo_data, m_ready,
        input  cmd_ready, fifo_rd_en, m_valid, m_data, m_last,
        input  busy, done
    );

    modport slave (
        input  cmd_valid, cmd_len, fifo_empty, fifo_data, m_ready,
        output cmd_ready, fifo_rd_en, m_valid, m_data, m_last,
        output busy, done
    );

endinterface

// File: rtl/sync_fifo_burst_reader_skid_buf.sv
// Three-entry in-order buffer catching registered FIFO read data.
// Caller guarantees no push when full and no pop when empty.
module fifo_rd_skid_buf
    import sync_fifo_pkg::*;
#(
    parameter int DATA_WIDTH = DATA_WIDTH_DEF
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  push,
    input  logic [DATA_WIDTH-1:0] din,
    input  logic                  pop,
    output logic [DATA_WIDTH-1:0] head,
    output logic [1:0]            occ
);

    logic [DATA_WIDTH-1:0] mem [SKID_DEPTH];
    logic [1:0]            wr_ptr;
    logic [1:0]            rd_ptr;

    function automatic logic [1:0] ptr_next(input logic [1:0] p);
        return (p == 2'(SKID_DEPTH - 1)) ? 2'd0 : p + 2'd1;
    endfunction

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            occ    <= '0;
            for (int i = 0; i < SKID_DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else begin
            if (push) begin
                mem[wr_ptr] <= din;
                wr_ptr      <= ptr_next(wr_ptr);
            end
            if (pop) begin
                rd_ptr <= ptr_next(rd_ptr);
            end
            if (push && !pop) begin
                occ <= occ + 2'd1;
            end else if (pop && !push) begin
                occ <= occ - 2'd1;
            end
        end
    end

    assign head = mem[rd_ptr];

endmodule

// File: rtl/sync_fifo_burst_reader.sv
// Burst read engine: pops N words from a registered-output FIFO
// and streams them out on valid/ready with last and done.
module sync_fifo_burst_reader
    import sync_fifo_pkg::*;
#(
    parameter int DATA_WIDTH = DATA_WIDTH_DEF,
    parameter int LEN_WIDTH  = 8
) (
    input logic                     clk,
    input logic                     rst,
    sync_fifo_burst_reader_if.slave bus
);

    rd_state_e             state;
    logic [LEN_WIDTH-1:0]  req_left;
    logic [LEN_WIDTH-1:0]  out_left;
    logic                  inflight;
    logic                  done_q;
    logic [1:0]            occ;
    logic [DATA_WIDTH-1:0] head;
    logic [2:0]            pending;
    logic                  rd_en;
    logic                  pop;
    logic                  cmd_hs;

    // Reads are gated only by registered state so m_ready never
    // reaches fifo_rd_en combinationally.
    assign pending = {1'b0, occ} + {2'b0, inflight};
    assign rd_en   = !rst && (state == READ) && !bus.fifo_empty
                   && (req_left != '0)
                   && (pending < 3'(SKID_DEPTH));
    assign pop     = (occ != 2'd0) && bus.m_ready;
    assign cmd_hs  = bus.cmd_valid && bus.cmd_ready;

    fifo_rd_skid_buf #(
        .DATA_WIDTH (DATA_WIDTH)
    ) u_skid (
        .clk  (clk),
        .rst  (rst),
        .push (inflight),
        .din  (bus.fifo_data),
        .pop  (pop),
        .head (head),
        .occ  (occ)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            req_left <= '0;
            out_left <= '0;
            inflight <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            inflight <= rd_en;
            done_q   <= 1'b0;
            if (rd_en) begin
                req_left <= req_left - LEN_WIDTH'(1);
            end
            if (pop && (out_left != '0)) begin
                out_left <= out_left - LEN_WIDTH'(1);
            end
            unique case (state)
                IDLE: begin
                    if (cmd_hs) begin
                        if (bus.cmd_len == '0) begin
                            done_q <= 1'b1;
                        end else begin
                            req_left <= bus.cmd_len;
                            out_left <= bus.cmd_len;
                            state    <= READ;
                        end
                    end
                end
                READ: begin
                    if (rd_en && (req_left == LEN_WIDTH'(1))) begin
                        state <= DRAIN;
                    end
                end
                DRAIN: begin
                    if (pop && (out_left == LEN_WIDTH'(1))) begin
                        state  <= IDLE;
                        done_q <= 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.cmd_ready  = !rst && (state == IDLE);
    assign bus.fifo_rd_en = rd_en;
    assign bus.m_valid    = (occ != 2'd0);
    assign bus.m_data     = head;
    assign bus.m_last     = (occ != 2'd0) && (out_left == LEN_WIDTH'(1));
    assign bus.busy       = (state != IDLE);
    assign bus.done       = done_q;

endmodule

// File: tb/tb_sync_fifo_burst_reader.sv
// Bench for sync_fifo_burst_reader: FIFO model, word scoreboard,
// directed scenarios and randomized bursts.
module tb_sync_fifo_burst_reader;

    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    sync_fifo_burst_reader_if #(.DATA_WIDTH(8), .LEN_WIDTH(8)) bus ();

    sync_fifo_burst_reader #(.DATA_WIDTH(8), .LEN_WIDTH(8)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    // FIFO contents and, separately, every word still owed downstream
    logic [7:0] fq[$];
    logic [7:0] sb[$];

    always @(posedge clk) begin
        if (bus.fifo_rd_en && fq.size() != 0) begin
            bus.fifo_data <= fq.pop_front();
        end
        bus.fifo_empty <= (fq.size() == 0);
    end

    task automatic push(input logic [7:0] d);
        fq.push_back(d);
        sb.push_back(d);
    endtask

    int         exp_left  = 0;
    int         out_cnt   = 0;
    int         hs_total  = 0;
    int         rd_total  = 0;
    bit         done_next = 0;
    bit         prev_stall = 0;
    logic [7:0] prev_data;
    logic       prev_last;

    always @(negedge clk) begin
        logic [7:0] w;
        if (rst) begin
            exp_left   = 0;
            out_cnt    = 0;
            done_next  = 0;
            prev_stall = 0;
        end else begin
            if (bus.done || done_next) check("done", bus.done, done_next);
            done_next = 0;
            if (prev_stall) begin
                check("stall_valid", bus.m_valid, 1);
                check("stall_data", bus.m_data, prev_data);
                check("stall_last", bus.m_last, prev_last);
            end
            if (bus.fifo_rd_en) begin
                check("rd_when_empty", bus.fifo_empty, 0);
                check("outstanding", out_cnt <= 2, 1);
                out_cnt++;
                rd_total++;
            end
            if (bus.m_valid && bus.m_ready) begin
                check("sb_nonempty", sb.size() != 0, 1);
                w = (sb.size() != 0) ? sb.pop_front() : 8'hxx;
                check("data", bus.m_data, w);
                check("last", bus.m_last, exp_left == 1);
                if (exp_left > 0) exp_left--;
                if (exp_left == 0) done_next = 1;
                out_cnt--;
                hs_total++;
            end
            if (bus.cmd_valid && bus.cmd_ready) begin
                exp_left = int'(bus.cmd_len);
                if (bus.cmd_len == 0) done_next = 1;
            end
            prev_stall = bus.m_valid && !bus.m_ready;
            prev_data  = bus.m_data;
            prev_last  = bus.m_last;
        end
    end

    task automatic issue_cmd(input int len);
        @(posedge clk); #1;
        bus.cmd_valid = 1'b1;
        bus.cmd_len   = 8'(len);
        @(negedge clk);
        check("cmd_ready", bus.cmd_ready, 1);
        @(posedge clk); #1;
        bus.cmd_valid = 1'b0;
    endtask

    task automatic run_to_done(input int to_push, input bit rnd_rdy,
                               input int bound);
        int n = 0;
        bit seen = 0;
        while (!seen && n < bound) begin
            @(posedge clk); #1;
            if (rnd_rdy) bus.m_ready = ($urandom_range(0, 3) != 0);
            if (to_push > 0 && $urandom_range(0, 1) == 1) begin
                push(8'($urandom_range(0, 255)));
                to_push--;
            end
            @(negedge clk);
            if (bus.done) seen = 1;
            n++;
        end
        check("done_seen", seen, 1);
    endtask

    initial begin
        int cnt;
        int r0;
        int start;
        int len;
        int pre;
        rst           = 1'b1;
        bus.cmd_valid = 1'b0;
        bus.cmd_len   = '0;
        bus.m_ready   = 1'b0;

        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_mvalid", bus.m_valid, 0);
        check("rst_rd_en", bus.fifo_rd_en, 0);
        check("rst_busy", bus.busy, 0);
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        check("rel_cmd_ready", bus.cmd_ready, 1);
        check("rel_done", bus.done, 0);

        // basic burst with exact timing
        bus.m_ready = 1'b1;
        for (int i = 0; i < 5; i++) push(8'h11 + 8'(i));
        issue_cmd(5);
        for (int n = 1; n <= 8; n++) begin
            @(negedge clk);
            check("basic_rd", bus.fifo_rd_en, n <= 5);
            if (n >= 3 && n <= 7) begin
                check("basic_valid", bus.m_valid, 1);
                check("basic_data", bus.m_data, 8'h10 + 8'(n - 2));
                check("basic_last", bus.m_last, n == 7);
            end
            if (n == 8) check("basic_done", bus.done, 1);
        end

        // backpressure
        bus.m_ready = 1'b0;
        for (int i = 0; i < 8; i++) push(8'h20 + 8'(i));
        issue_cmd(8);
        cnt = 0;
        for (int n = 1; n <= 6; n++) begin
            @(negedge clk);
            if (bus.fifo_rd_en) cnt++;
        end
        check("bp_reads", cnt, 3);
        check("bp_head", bus.m_data, 8'h20);
        bus.m_ready = 1'b1;
        run_to_done(0, 0, 60);

        // underrun
        r0 = rd_total;
        issue_cmd(3);
        for (int i = 0; i < 3; i++) begin
            repeat (4) @(posedge clk);
            #1;
            push(8'hA1 + 8'(i));
        end
        run_to_done(0, 0, 40);
        check("ur_reads", rd_total - r0, 3);

        // zero length
        r0 = rd_total;
        issue_cmd(0);
        @(negedge clk);
        check("zl_done", bus.done, 1);
        check("zl_busy", bus.busy, 0);
        repeat (3) begin
            @(negedge clk);
            check("zl_mvalid", bus.m_valid, 0);
            check("zl_busy2", bus.busy, 0);
        end
        check("zl_reads", rd_total - r0, 0);

        // abort mid-burst by reset
        for (int i = 0; i < 6; i++) push(8'h30 + 8'(i));
        start = hs_total;
        issue_cmd(6);
        cnt = 0;
        while (hs_total < start + 2 && cnt < 30) begin
            @(negedge clk);
            cnt++;
        end
        check("abort_hs", hs_total - start >= 2, 1);
        @(posedge clk); #1;
        rst = 1'b1;
        fq.delete();
        sb.delete();
        @(posedge clk);
        @(negedge clk);
        check("abort_mvalid", bus.m_valid, 0);
        check("abort_mlast", bus.m_last, 0);
        check("abort_rd_en", bus.fifo_rd_en, 0);
        check("abort_busy", bus.busy, 0);
        check("abort_done", bus.done, 0);
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        check("abort_cmd_ready", bus.cmd_ready, 1);
        check("abort_no_done", bus.done, 0);
        push(8'h40);
        push(8'h41);
        issue_cmd(2);
        run_to_done(0, 0, 30);

        // randomized bursts
        for (int b = 0; b < 20; b++) begin
            len = $urandom_range(0, 12);
            pre = $urandom_range(0, len);
            for (int i = 0; i < pre; i++) push(8'($urandom_range(0, 255)));
            issue_cmd(len);
            if (len == 0) begin
                @(negedge clk);
                check("rnd_zl_done", bus.done, 1);
            end else begin
                run_to_done(len - pre, 1, 400);
            end
            check("rnd_sb_empty", sb.size(), 0);
        end

        repeat (3) @(posedge clk);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
